// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: captures matrix element loads into A/B banks, then streams
// N (A column k, B row k) beats to the matrix unit over a valid/ready handshake.
module matrix_operand_loader #(
  parameter int N = 4,
  parameter int DATA_W = 32,
  localparam int KW = $clog2(N),
  localparam int IDXW = 2 * KW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_load_a_en,
  input  logic              mem_load_b_en,
  input  logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              stall_o,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*DATA_W-1:0] out_a_col,
  output logic [N*DATA_W-1:0] out_b_row,
  output logic [KW-1:0]     out_k,
  output logic              out_last,
  output logic              a_full,
  output logic              b_full,
  output logic              done
);
  typedef enum logic [1:0] {LOAD, STREAM, DONE} state_t;
  state_t r_state;
  logic [DATA_W-1:0] r_a [N*N];
  logic [DATA_W-1:0] r_b [N*N];
  logic [N*N-1:0] r_mask_a, r_mask_b, w_mask_a, w_mask_b;
  logic [KW-1:0] r_k;
  logic r_valid, r_done;
  logic [IDXW-1:0] w_idx;
  logic w_load, w_wr_a, w_wr_b, w_unused;

  assign w_idx = mem_addr[2 +: IDXW];
  assign w_unused = ^{mem_addr[31:2+IDXW], mem_addr[1:0]};
  assign w_load = r_state == LOAD;
  assign w_wr_a = w_load & mem_load_a_en;
  assign w_wr_b = w_load & mem_load_b_en;
  assign w_mask_a = r_mask_a | ((N*N)'(w_wr_a) << w_idx);
  assign w_mask_b = r_mask_b | ((N*N)'(w_wr_b) << w_idx);
  assign stall_o = (mem_load_a_en | mem_load_b_en) & ~w_load;
  assign a_full = &r_mask_a;
  assign b_full = &r_mask_b;
  assign out_valid = r_valid;
  assign out_k = r_k;
  assign out_last = r_valid & (r_k == KW'(N - 1));
  assign done = r_done;

  // A column k gathers A[r][k]; B row k gathers B[k][c]
  for (genvar i = 0; i < N; i++) begin : g_out
    assign out_a_col[i*DATA_W +: DATA_W] = r_valid ? r_a[{KW'(i), r_k}] : '0;
    assign out_b_row[i*DATA_W +: DATA_W] = r_valid ? r_b[{r_k, KW'(i)}] : '0;
  end

  always_ff @(posedge clk) begin
    if (w_wr_a) r_a[w_idx] <= mem_wdata;
    if (w_wr_b) r_b[w_idx] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LOAD;
      r_mask_a <= '0;
      r_mask_b <= '0;
      r_k <= '0;
      r_valid <= 1'b0;
      r_done <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_mask_a <= w_mask_a;
          r_mask_b <= w_mask_b;
          if (&w_mask_a && &w_mask_b) begin
            r_state <= STREAM;
            r_k <= '0;
            r_valid <= 1'b1;
          end
        end
        STREAM: if (out_ready) begin
          if (r_k == KW'(N - 1)) begin
            r_state <= DONE;
            r_valid <= 1'b0;
            r_done <= 1'b1;
            r_k <= '0;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DONE: begin
          r_done <= 1'b0;
          r_mask_a <= '0;
          r_mask_b <= '0;
          r_k <= '0;
          r_state <= LOAD;
        end
        default: r_state <= LOAD;
      endcase
    end
  end
endmodule
